// File: rtl/ttt_pkg.sv
// Shared types for the N x N game controller: screen states, winner codes and
// the row/column to flat cell index mapping used by the board vectors.
package ttt_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    CHECK = 3'd2,
    WIN   = 3'd3,
    DRAW  = 3'd4
  } game_state_t;

  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_P1   = 2'b01;
  localparam logic [1:0] W_P2   = 2'b10;

  function automatic int cell_idx(input int row, input int col, input int n);
    return row * n + col;
  endfunction

endpackage

// File: rtl/ttt_win_detect.sv
// Combinational line detector: win is high when one player's board holds a
// complete row, column, main diagonal or anti-diagonal.
module ttt_win_detect
  import ttt_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N*N-1:0] board,
  output logic           win
);

  logic [N-1:0] w_row_win;
  logic [N-1:0] w_col_win;
  logic [N-1:0] w_diag;
  logic [N-1:0] w_anti;

  for (genvar i = 0; i < N; i++) begin : g_line
    logic [N-1:0] w_row;
    logic [N-1:0] w_col;
    for (genvar j = 0; j < N; j++) begin : g_cell
      assign w_row[j] = board[cell_idx(i, j, N)];
      assign w_col[j] = board[cell_idx(j, i, N)];
    end
    assign w_row_win[i] = &w_row;
    assign w_col_win[i] = &w_col;
    assign w_diag[i]    = board[cell_idx(i, i, N)];
    assign w_anti[i]    = board[cell_idx(i, N - 1 - i, N)];
  end

  assign win = (|w_row_win) | (|w_col_win) | (&w_diag) | (&w_anti);

endmodule

// File: rtl/ttt_game_ctrl.sv
// Two-player N x N game controller: board, cursor, turn order, per-turn timer
// and win/draw detection. Define AUTO_MOVE_EN to auto-place a mark on timeout.
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter int N             = 3,
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int TURN_SECS     = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      move_next,
  input  logic                      confirm,
  input  logic                      abort,
  output logic [2:0]                state,
  output logic [N*N-1:0]            board_p1,
  output logic [N*N-1:0]            board_p2,
  output logic [$clog2(N*N)-1:0]    cursor,
  output logic                      turn,
  output logic [6:0]                secs_left,
  output logic [1:0]                winner,
  output logic                      load
);

  localparam int CW = $clog2(N*N);
  localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST_CELL = CW'(N*N - 1);
  localparam logic [TW-1:0] TICK_MAX  = TW'(TICKS_PER_SEC - 1);
  localparam logic [6:0]    SECS_INIT = 7'(TURN_SECS);

  game_state_t    r_state,  w_state;
  logic [N*N-1:0] r_p1,     w_p1;
  logic [N*N-1:0] r_p2,     w_p2;
  logic [CW-1:0]  r_cursor, w_cursor;
  logic           r_turn,   w_turn;
  logic [6:0]     r_secs,   w_secs;
  logic [TW-1:0]  r_tick,   w_tick;
  logic [1:0]     r_winner, w_winner;
  logic           r_load,   w_load;

  logic [N*N-1:0] w_occupied;
  logic [N*N-1:0] w_mark;
  logic [CW-1:0]  w_place;
  logic           w_do_mark;
  logic           w_win;

  assign w_occupied = r_p1 | r_p2;

  // CHECK always follows the mark, so the mover's board already holds it.
  ttt_win_detect #(.N(N)) u_win_detect (
    .board (r_turn ? r_p2 : r_p1),
    .win   (w_win)
  );

  // NOTE: every variable gets a default at the top so no branch can infer a latch.
  always_comb begin
    w_state   = r_state;
    w_p1      = r_p1;
    w_p2      = r_p2;
    w_cursor  = r_cursor;
    w_turn    = r_turn;
    w_secs    = r_secs;
    w_tick    = r_tick;
    w_winner  = r_winner;
    w_load    = 1'b0;
    w_do_mark = 1'b0;
    w_place   = r_cursor;
    w_mark    = '0;

    if (abort) begin
      w_state  = IDLE;
      w_p1     = '0;
      w_p2     = '0;
      w_winner = W_NONE;
      w_secs   = SECS_INIT;
      w_tick   = '0;
    end else if (start && (r_state == IDLE || r_state == WIN || r_state == DRAW)) begin
      w_state  = PLAY;
      w_p1     = '0;
      w_p2     = '0;
      w_turn   = 1'b0;
      w_cursor = '0;
      w_secs   = SECS_INIT;
      w_tick   = '0;
      w_winner = W_NONE;
    end else begin
      case (r_state)
        PLAY: begin
          if (confirm && !w_occupied[r_cursor]) begin
            w_do_mark = 1'b1;
          end else if (r_secs == 7'd0) begin
`ifdef AUTO_MOVE_EN
            for (int i = N*N - 1; i >= 0; i--) begin
              if (!w_occupied[i]) w_place = CW'(i);
            end
            w_do_mark = 1'b1;
`else
            w_turn = ~r_turn;
            w_secs = SECS_INIT;
            w_tick = '0;
`endif
          end else begin
            if (move_next) w_cursor = (r_cursor == LAST_CELL) ? '0 : r_cursor + 1'b1;
            // A wrap at secs_left==1 shows 0 for a cycle; the timeout fires next.
            if (r_tick == TICK_MAX) begin
              w_tick = '0;
              w_secs = r_secs - 7'd1;
            end else begin
              w_tick = r_tick + 1'b1;
            end
          end
        end
        CHECK: begin
          if (w_win) begin
            w_state  = WIN;
            w_winner = r_turn ? W_P2 : W_P1;
          end else if (&w_occupied) begin
            w_state = DRAW;
          end else begin
            w_turn  = ~r_turn;
            w_secs  = SECS_INIT;
            w_tick  = '0;
            w_state = PLAY;
          end
        end
        default: ;
      endcase
    end

    if (w_do_mark) begin
      w_mark[w_place] = 1'b1;
      if (r_turn) w_p2 = r_p2 | w_mark;
      else        w_p1 = r_p1 | w_mark;
      w_load  = 1'b1;
      w_state = CHECK;
    end
  end

  // NOTE: state registers use non-blocking assignments and a reset sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_p1     <= '0;
      r_p2     <= '0;
      r_cursor <= '0;
      r_turn   <= 1'b0;
      r_secs   <= SECS_INIT;
      r_tick   <= '0;
      r_winner <= W_NONE;
      r_load   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_p1     <= w_p1;
      r_p2     <= w_p2;
      r_cursor <= w_cursor;
      r_turn   <= w_turn;
      r_secs   <= w_secs;
      r_tick   <= w_tick;
      r_winner <= w_winner;
      r_load   <= w_load;
    end
  end

  assign state     = r_state;
  assign board_p1  = r_p1;
  assign board_p2  = r_p2;
  assign cursor    = r_cursor;
  assign turn      = r_turn;
  assign secs_left = r_secs;
  assign winner    = r_winner;
  assign load      = r_load;

endmodule
